instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Writer side of the instruction memory that program_counter reads from.
- Accepts a byte stream over a valid/ready handshake and assembles each group of 4 bytes into a 32-bit instruction word, first byte in the MSB.
- Issues one single-cycle write per word into the 14-bit-addressed instruction memory.
- Replaces file preloading, so programs can be loaded at run time before fetch starts.

Parameters:
- ADDR_W, 14, instruction memory address width; same width as pc/next.
- DATA_W, 32, instruction word width; fixed at 4 bytes.
- START_ADDR, 0, first word address written after start.
- LOAD_WORDS, 256, number of words written per load, range 1..2^ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a load when sampled high in IDLE.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction memory write strobe.
- wr_addr  output  ADDR_W  memory word address.
- wr_data  output  DATA_W  assembled instruction word.
- busy  output  1  load in progress.
- done  output  1  last load completed; sticky.
- word_count  output  ADDR_W+1  words written in the current or last load.

Behaviour:

Reset (rst high, asynchronous):
- State goes to IDLE.
- byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, word_count=0.
- Internal byte index and shift register are cleared.
- Reset mid-load discards any partial word and issues no write.

States:

IDLE:
- byte_ready=0, busy=0.
- start=1 → COLLECT next cycle, with wr_addr=START_ADDR, word_count=0, done=0, byte index=0.

COLLECT:
- byte_ready=1, busy=1.
- A byte is accepted only when byte_valid && byte_ready. It shifts in: shreg <= {shreg[23:0], byte_in}; index is incremented.
- On the 4th accepted byte (index 3) → WRITE. wr_data is registered from the full shift value in the same edge.
- No accept while byte_valid=0; the state holds indefinitely.

WRITE (exactly 1 cycle):
- wr_en=1, byte_ready=0, busy=1.
- wr_addr/wr_data are stable for the whole cycle.
- On exit: wr_addr <= wr_addr+1 (modulo 2^ADDR_W, so 16383+1 → 0), word_count+1, index=0.
- Next state: DONE if the new word_count == LOAD_WORDS, otherwise COLLECT.

DONE (1 cycle):
- busy=0, done=1.
- Next cycle → IDLE.
- done stays high in IDLE until the next accepted start or reset.

Timing and arithmetic:
- Minimum throughput is 5 cycles per word: 4 accepts + 1 write. byte_ready drops during WRITE, so a byte presented then stays pending until COLLECT.
- Latency from the 4th accepted byte edge to wr_en high is 1 cycle (wr_en is registered).
- word_count is ADDR_W+1 bits so a full 2^14 count is representable.

Boundary conditions:
- start while busy is ignored.
- start held high after DONE starts a new load from IDLE.
- byte_valid in IDLE/DONE is not accepted (byte_ready=0); the byte is not consumed.
- wr_en is never high outside WRITE.

Test Plan:
- Reset then start, LOAD_WORDS=2, bytes 0x8C,0x01,0x00,0x04,0x00,0x22,0x18,0x20 with continuous valid → wr_en pulses twice: (addr 0, 0x8C010004) then (addr 1, 0x00221820). done=1, word_count=2, no further writes.
- Same stream with byte_valid low on alternating cycles → identical writes; each wr_en exactly 1 cycle; byte_ready=0 during the WRITE cycles.
- START_ADDR=16382, LOAD_WORDS=3 → wr_addr sequence 16382, 16383, 0.
- Assert rst asynchronously after 2 bytes of word 1 → all outputs 0 immediately with no write. Restart loads the full first word correctly from byte 0.
- Pulse start during COLLECT and during WRITE → no change to wr_addr or word_count. After DONE, assert start → done clears next cycle and wr_addr returns to START_ADDR.
- Hold byte_valid high in IDLE with byte 0xFF, then start → the first word assembled begins with 0xFF accepted in COLLECT only, not in IDLE; exactly 4 bytes are consumed per word.

Source files
------------

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//   Write side of the instruction memory. A byte stream arrives over a
//   valid/ready handshake. Every 4 accepted bytes are packed into one 32-bit
//   instruction word, with the first byte in the MSB. Each word is written
//   with a single-cycle strobe. A load covers LOAD_WORDS consecutive word
//   addresses, starting at START_ADDR and wrapping modulo 2^ADDR_W.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begins a load when sampled high in IDLE
//   byte_in    in   stream byte
//   byte_valid in   byte_in valid this cycle
//   byte_ready out  loader accepts a byte this cycle (COLLECT only)
//   wr_en      out  instruction memory write strobe (WRITE only)
//   wr_addr    out  memory word address
//   wr_data    out  assembled instruction word
//   busy       out  load in progress (COLLECT or WRITE)
//   done       out  last load completed; sticky until next start or reset
//   word_count out  words written in the current or last load
// -----------------------------------------------------------------------------
module instr_mem_loader #(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 32,
   parameter int START_ADDR = 0,
   parameter int LOAD_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_WRITE   = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W:0]   LOAD_N  = (ADDR_W+1)'(LOAD_WORDS);

   logic [1:0]        state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   // Only the three earlier bytes need holding; the fourth comes straight
   // from byte_in on the completing edge.
   logic [DATA_W-9:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d, cnt_inc;
   logic              done_q, done_d;

   assign cnt_inc = cnt_q + (ADDR_W+1)'(1);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      wr_data_d = wr_data_q;
      wr_addr_d = wr_addr_q;
      cnt_d     = cnt_q;
      done_d    = done_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_COLLECT;
               wr_addr_d = START_A;
               cnt_d     = '0;
               done_d    = 1'b0;
               idx_d     = '0;
            end
         end
         S_COLLECT: begin
            // byte_ready is high throughout COLLECT, so valid alone means accept
            if (byte_valid) begin
               shreg_d = {shreg_q[DATA_W-17:0], byte_in};
               idx_d   = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  wr_data_d = {shreg_q, byte_in};
                  state_d   = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);   // wraps at 2^ADDR_W
            cnt_d     = cnt_inc;
            idx_d     = '0;
            if (cnt_inc == LOAD_N) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = S_COLLECT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         shreg_q   <= '0;
         wr_data_q <= '0;
         wr_addr_q <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         wr_data_q <= wr_data_d;
         wr_addr_q <= wr_addr_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
      end
   end

   assign byte_ready = (state_q == S_COLLECT);
   assign wr_en      = (state_q == S_WRITE);
   assign busy       = (state_q == S_COLLECT) || (state_q == S_WRITE);
   assign done       = done_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign word_count = cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
//   Directed bench for instr_mem_loader. Instance A: START_ADDR=0, LOAD_WORDS=2.
//   Instance B: START_ADDR=16382, LOAD_WORDS=3, which exercises address wrap.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;

   logic        a_start, a_valid;
   logic [7:0]  a_byte;
   logic        a_ready, a_wr_en, a_busy, a_done;
   logic [13:0] a_addr;
   logic [31:0] a_data;
   logic [14:0] a_cnt;

   logic        b_start, b_valid;
   logic [7:0]  b_byte;
   logic        b_ready, b_wr_en, b_busy, b_done;
   logic [13:0] b_addr;
   logic [31:0] b_data;
   logic [14:0] b_cnt;

   instr_mem_loader #(.ADDR_W(14), .DATA_W(32), .START_ADDR(0), .LOAD_WORDS(2)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .byte_in(a_byte), .byte_valid(a_valid),
      .byte_ready(a_ready), .wr_en(a_wr_en), .wr_addr(a_addr), .wr_data(a_data),
      .busy(a_busy), .done(a_done), .word_count(a_cnt)
   );

   instr_mem_loader #(.ADDR_W(14), .DATA_W(32), .START_ADDR(16382), .LOAD_WORDS(3)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .byte_in(b_byte), .byte_valid(b_valid),
      .byte_ready(b_ready), .wr_en(b_wr_en), .wr_addr(b_addr), .wr_data(b_data),
      .busy(b_busy), .done(b_done), .word_count(b_cnt)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write recorders; also count strobe-rule violations (ready during write,
   // write while not busy, strobe longer than one cycle).
   logic [13:0] qa_addr[$];
   logic [31:0] qa_data[$];
   logic [13:0] qb_addr[$];
   logic [31:0] qb_data[$];
   int   a_viol = 0;
   logic a_wr_prev = 1'b0;

   always @(negedge clk) begin
      if (a_wr_en) begin
         qa_addr.push_back(a_addr);
         qa_data.push_back(a_data);
         if (a_ready || !a_busy || a_wr_prev) a_viol++;
      end
      a_wr_prev = a_wr_en;
      if (b_wr_en) begin
         qb_addr.push_back(b_addr);
         qb_data.push_back(b_data);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(input bit use_b);
      if (use_b) b_start = 1'b1; else a_start = 1'b1;
      step(1);
      if (use_b) b_start = 1'b0; else a_start = 1'b0;
   endtask

   // Present one byte until accepted, then optionally idle 'gap' cycles.
   task automatic send(input bit use_b, input logic [7:0] b, input int gap);
      bit r;
      int n;
      r = 1'b0;
      n = 0;
      if (use_b) begin b_byte = b; b_valid = 1'b1; end
      else       begin a_byte = b; a_valid = 1'b1; end
      while (!r && n < 40) begin
         @(negedge clk);
         r = use_b ? b_ready : a_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!r) check("send_timeout", 32'd0, 32'd1);
      if (use_b) b_valid = 1'b0; else a_valid = 1'b0;
      step(gap);
   endtask

   task automatic clear_a();
      qa_addr.delete();
      qa_data.delete();
   endtask

   logic [7:0] stream [8] = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};

   initial begin
      rst = 1'b1;
      a_start = 1'b0; a_valid = 1'b0; a_byte = 8'h00;
      b_start = 1'b0; b_valid = 1'b0; b_byte = 8'h00;
      step(2);
      check("rst_ready", {31'd0, a_ready}, 32'd0);
      check("rst_wr_en", {31'd0, a_wr_en}, 32'd0);
      check("rst_addr", {18'd0, a_addr}, 32'd0);
      check("rst_data", a_data, 32'd0);
      check("rst_busy", {31'd0, a_busy}, 32'd0);
      check("rst_done", {31'd0, a_done}, 32'd0);
      check("rst_cnt", {17'd0, a_cnt}, 32'd0);
      rst = 1'b0;
      step(1);

      // Two-word load, continuous valid
      clear_a();
      pulse_start(1'b0);
      check("t1_busy", {31'd0, a_busy}, 32'd1);
      for (int i = 0; i < 8; i++) send(1'b0, stream[i], 0);
      step(6);
      check("t1_nwr", qa_addr.size(), 32'd2);
      if (qa_addr.size() == 2) begin
         check("t1_addr0", {18'd0, qa_addr[0]}, 32'd0);
         check("t1_data0", qa_data[0], 32'h8C010004);
         check("t1_addr1", {18'd0, qa_addr[1]}, 32'd1);
         check("t1_data1", qa_data[1], 32'h00221820);
      end
      check("t1_done", {31'd0, a_done}, 32'd1);
      check("t1_cnt", {17'd0, a_cnt}, 32'd2);
      check("t1_idle_busy", {31'd0, a_busy}, 32'd0);
      check("t1_viol", a_viol, 32'd0);

      // Same stream, valid low on alternate cycles
      clear_a();
      pulse_start(1'b0);
      check("t2_done_clr", {31'd0, a_done}, 32'd0);
      check("t2_addr_start", {18'd0, a_addr}, 32'd0);
      check("t2_cnt_clr", {17'd0, a_cnt}, 32'd0);
      for (int i = 0; i < 8; i++) send(1'b0, stream[i], 1);
      step(6);
      check("t2_nwr", qa_addr.size(), 32'd2);
      if (qa_addr.size() == 2) begin
         check("t2_addr0", {18'd0, qa_addr[0]}, 32'd0);
         check("t2_data0", qa_data[0], 32'h8C010004);
         check("t2_addr1", {18'd0, qa_addr[1]}, 32'd1);
         check("t2_data1", qa_data[1], 32'h00221820);
      end
      check("t2_viol", a_viol, 32'd0);
      check("t2_done", {31'd0, a_done}, 32'd1);

      // Asynchronous reset after two bytes of word 1
      clear_a();
      pulse_start(1'b0);
      send(1'b0, 8'h8C, 0);
      send(1'b0, 8'h01, 0);
      #1 rst = 1'b1;
      #1;
      check("ar_ready", {31'd0, a_ready}, 32'd0);
      check("ar_busy", {31'd0, a_busy}, 32'd0);
      check("ar_wr_en", {31'd0, a_wr_en}, 32'd0);
      check("ar_data", a_data, 32'd0);
      check("ar_addr", {18'd0, a_addr}, 32'd0);
      check("ar_cnt", {17'd0, a_cnt}, 32'd0);
      step(1);
      rst = 1'b0;
      step(3);
      check("ar_nowr", qa_addr.size(), 32'd0);

      // Restart, then start pulses during COLLECT and WRITE
      pulse_start(1'b0);
      send(1'b0, 8'h11, 0);
      send(1'b0, 8'h22, 0);
      send(1'b0, 8'h33, 0);
      send(1'b0, 8'h44, 0);
      step(2);
      check("rs_nwr", qa_addr.size(), 32'd1);
      if (qa_addr.size() == 1) begin
         check("rs_addr0", {18'd0, qa_addr[0]}, 32'd0);
         check("rs_data0", qa_data[0], 32'h11223344);
      end
      pulse_start(1'b0);
      check("sc_addr", {18'd0, a_addr}, 32'd1);
      check("sc_cnt", {17'd0, a_cnt}, 32'd1);
      check("sc_busy", {31'd0, a_busy}, 32'd1);
      send(1'b0, 8'h55, 0);
      send(1'b0, 8'h66, 0);
      send(1'b0, 8'h77, 0);
      send(1'b0, 8'h88, 0);
      check("sw_in_write", {31'd0, a_wr_en}, 32'd1);
      a_start = 1'b1;
      step(1);
      check("sw_addr", {18'd0, a_addr}, 32'd2);
      check("sw_cnt", {17'd0, a_cnt}, 32'd2);
      check("sw_done", {31'd0, a_done}, 32'd1);
      check("sw_busy", {31'd0, a_busy}, 32'd0);
      step(1);
      check("hold_idle_done", {31'd0, a_done}, 32'd1);
      check("hold_idle_busy", {31'd0, a_busy}, 32'd0);
      step(1);
      a_start = 1'b0;
      check("hold_done_clr", {31'd0, a_done}, 32'd0);
      check("hold_addr", {18'd0, a_addr}, 32'd0);
      check("hold_cnt", {17'd0, a_cnt}, 32'd0);
      check("hold_busy", {31'd0, a_busy}, 32'd1);
      if (qa_data.size() == 2) check("sw_data1", qa_data[1], 32'h55667788);
      else check("sw_nwr", qa_data.size(), 32'd2);

      // Byte held valid in IDLE must not be consumed there
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      clear_a();
      a_byte = 8'hFF;
      a_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_ready", {31'd0, a_ready}, 32'd0);
      end
      step(1);
      pulse_start(1'b0);
      send(1'b0, 8'hFF, 0);
      send(1'b0, 8'h01, 0);
      send(1'b0, 8'h02, 0);
      send(1'b0, 8'h03, 0);
      step(3);
      check("ff_nwr", qa_addr.size(), 32'd1);
      if (qa_addr.size() == 1) begin
         check("ff_addr", {18'd0, qa_addr[0]}, 32'd0);
         check("ff_data", qa_data[0], 32'hFF010203);
      end
      check("ff_cnt", {17'd0, a_cnt}, 32'd1);
      check("ff_busy", {31'd0, a_busy}, 32'd1);

      // Address wrap on instance B
      pulse_start(1'b1);
      for (int i = 0; i < 12; i++) send(1'b1, 8'(i), 0);
      step(6);
      check("wr_nwr", qb_addr.size(), 32'd3);
      if (qb_addr.size() == 3) begin
         check("wr_addr0", {18'd0, qb_addr[0]}, 32'd16382);
         check("wr_addr1", {18'd0, qb_addr[1]}, 32'd16383);
         check("wr_addr2", {18'd0, qb_addr[2]}, 32'd0);
         check("wr_data0", qb_data[0], 32'h00010203);
         check("wr_data2", qb_data[2], 32'h08090A0B);
      end
      check("wr_done", {31'd0, b_done}, 32'd1);
      check("wr_cnt", {17'd0, b_cnt}, 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
